// File: rtl/adder_bcd_seq_if.sv
// Operand/request and result/display bundle for adder_bcd_seq.
// The master drives operands and start; the slave returns status, result and display data.
interface adder_bcd_seq_if #(
   parameter int W      = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic                  sub;
   logic [W-1:0]          a;
   logic [W-1:0]          b;
   logic                  cin;
   logic                  busy;
   logic                  done;
   logic [W:0]            result;
   logic                  neg;
   logic [4*DIGITS-1:0]   bcd;
   logic [7*DIGITS-1:0]   seg;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, result, neg, bcd, seg
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, result, neg, bcd, seg
   );
endinterface

// File: rtl/adder_bcd_seq.sv
// Add / absolute-difference unit followed by a bit-serial shift-and-add-3 BCD
// converter and active-low 7-segment drivers with leading-zero blanking.
module adder_bcd_seq #(
   parameter int W      = 8,
   parameter int DIGITS = 3
) (
   input  logic           CLOCK_50,
   input  logic           RESET_N,
   adder_bcd_seq_if.slave bus
);

   localparam int RW = W + 1;
   localparam int SW = 4 * DIGITS;
   localparam int CW = $clog2(W + 2);

   typedef enum logic [1:0] {IDLE, ADD, CONV, DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CW-1:0]       cnt;

   logic [W-1:0]        a_p0;
   logic [W-1:0]        b_p0;
   logic                sub_p0;
   logic                cin_p0;

   logic [RW-1:0]       r_calc;
   logic                neg_calc;
   logic [RW-1:0]       r_p1;
   logic                neg_p1;

   logic [RW-1:0]       sh_r;
   logic [SW-1:0]       scr;
   logic [SW-1:0]       scr_adj;
   logic [SW+RW-1:0]    shifted;
   logic                last_shift;

   logic [RW-1:0]       result_q;
   logic                neg_q;
   logic [SW-1:0]       bcd_q;
   logic [7*DIGITS-1:0] seg_q;

   function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
      logic [SW-1:0] o;
      o = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5)
            o[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
      return o;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] o;
      case (d)
         4'd0:    o = ~7'h3F;
         4'd1:    o = ~7'h06;
         4'd2:    o = ~7'h5B;
         4'd3:    o = ~7'h4F;
         4'd4:    o = ~7'h66;
         4'd5:    o = ~7'h6D;
         4'd6:    o = ~7'h7D;
         4'd7:    o = ~7'h07;
         4'd8:    o = ~7'h7F;
         4'd9:    o = ~7'h67;
         default: o = 7'h7F;
      endcase
      return o;
   endfunction

   // Walk from the top digit down; digits stay blank until the first non-zero one.
   function automatic logic [7*DIGITS-1:0] seg_map(input logic [SW-1:0] d);
      logic [7*DIGITS-1:0] o;
      logic                lead;
      o    = '1;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (d[4*i +: 4] != 4'd0)
            lead = 1'b0;
         if (lead && (i != 0))
            o[7*i +: 7] = 7'h7F;
         else
            o[7*i +: 7] = seg7(d[4*i +: 4]);
      end
      return o;
   endfunction

   always_comb begin
      r_calc   = '0;
      neg_calc = 1'b0;
      if (!sub_p0) begin
         r_calc = {1'b0, a_p0} + {1'b0, b_p0} + {{W{1'b0}}, cin_p0};
      end else if (a_p0 >= b_p0) begin
         r_calc = {1'b0, a_p0 - b_p0};
      end else begin
         r_calc   = {1'b0, b_p0 - a_p0};
         neg_calc = 1'b1;
      end
   end

   assign scr_adj    = add3(scr);
   assign shifted    = {scr_adj, sh_r} << 1;
   assign last_shift = (state == CONV) && (cnt == CW'(W));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = ADD;
         ADD:     state_nxt = CONV;
         CONV:    if (cnt == CW'(W)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         cnt      <= '0;
         result_q <= '0;
         neg_q    <= 1'b0;
         bcd_q    <= '0;
         seg_q    <= '1;
      end else begin
         state <= state_nxt;
         if (state == ADD)
            cnt <= '0;
         else if (state == CONV)
            cnt <= cnt + CW'(1);
         if (last_shift) begin
            result_q <= r_p1;
            neg_q    <= neg_p1;
            bcd_q    <= shifted[SW+RW-1:RW];
            seg_q    <= seg_map(shifted[SW+RW-1:RW]);
         end
      end
   end

   // Stage p0: operand capture on accept
   always_ff @(posedge CLOCK_50) begin
      if ((state == IDLE) && bus.start) begin
         a_p0   <= bus.a;
         b_p0   <= bus.b;
         sub_p0 <= bus.sub;
         cin_p0 <= bus.cin;
      end
   end

   // Stage p1: arithmetic result, then the serial double-dabble shifts
   always_ff @(posedge CLOCK_50) begin
      if (state == ADD) begin
         r_p1   <= r_calc;
         neg_p1 <= neg_calc;
         sh_r   <= r_calc;
         scr    <= '0;
      end else if (state == CONV) begin
         scr    <= shifted[SW+RW-1:RW];
         sh_r   <= shifted[RW-1:0];
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = (state == DONE);
   assign bus.result = result_q;
   assign bus.neg    = neg_q;
   assign bus.bcd    = bcd_q;
   assign bus.seg    = seg_q;

endmodule

// File: tb/tb_adder_bcd_seq.sv
// Directed bench for adder_bcd_seq: W=8/DIGITS=3 main instance plus W=6 and W=16 sweeps.
module tb_adder_bcd_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   adder_bcd_seq_if #(.W(8),  .DIGITS(3)) i8  ();
   adder_bcd_seq_if #(.W(6),  .DIGITS(3)) i6  ();
   adder_bcd_seq_if #(.W(16), .DIGITS(6)) i16 ();

   adder_bcd_seq #(.W(8),  .DIGITS(3)) u8  (.CLOCK_50(clk), .RESET_N(rst_n), .bus(i8));
   adder_bcd_seq #(.W(6),  .DIGITS(3)) u6  (.CLOCK_50(clk), .RESET_N(rst_n), .bus(i6));
   adder_bcd_seq #(.W(16), .DIGITS(6)) u16 (.CLOCK_50(clk), .RESET_N(rst_n), .bus(i16));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One transaction on the W=8 instance; latency counts cycles from the accept edge.
   task automatic run8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                       input logic vs, input logic vc, input logic [8:0] e_res,
                       input logic e_neg, input logic [11:0] e_bcd, input logic [20:0] e_seg);
      int lat;
      int bcnt;
      @(negedge clk);
      i8.a = va; i8.b = vb; i8.sub = vs; i8.cin = vc; i8.start = 1'b1;
      @(negedge clk);
      i8.start = 1'b0; i8.a = ~va; i8.b = ~vb;
      lat = 1; bcnt = 0;
      while (!i8.done && lat < 40) begin
         if (i8.busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (i8.busy) bcnt++;
      check({tag, "_done"}, i8.done, 1);
      check({tag, "_lat"}, lat, 11);
      check({tag, "_busy_cyc"}, bcnt, 11);
      check({tag, "_res"}, i8.result, e_res);
      check({tag, "_neg"}, i8.neg, e_neg);
      check({tag, "_bcd"}, i8.bcd, e_bcd);
      check({tag, "_seg"}, i8.seg, e_seg);
      @(negedge clk);
      check({tag, "_done_fall"}, i8.done, 0);
      check({tag, "_busy_fall"}, i8.busy, 0);
   endtask

   initial begin
      int lat;
      int t1;
      int t2;
      int ndone;
      {i8.start, i8.sub, i8.cin, i8.a, i8.b}     = '0;
      {i6.start, i6.sub, i6.cin, i6.a, i6.b}     = '0;
      {i16.start, i16.sub, i16.cin, i16.a, i16.b} = '0;

      repeat (3) @(negedge clk);
      check("rst_busy", i8.busy, 0);
      check("rst_done", i8.done, 0);
      check("rst_res", i8.result, 0);
      check("rst_neg", i8.neg, 0);
      check("rst_bcd", i8.bcd, 0);
      check("rst_seg", i8.seg, 21'h1FFFFF);
      rst_n = 1'b1;
      @(negedge clk);

      run8("add200_55", 8'd200, 8'd55, 1'b0, 1'b0, 9'd255, 1'b0, 12'h255, {7'h24, 7'h12, 7'h12});
      repeat (3) @(negedge clk);
      check("hold_res", i8.result, 9'd255);
      check("hold_seg", i8.seg, {7'h24, 7'h12, 7'h12});

      run8("add_max", 8'd255, 8'd255, 1'b0, 1'b1, 9'd511, 1'b0, 12'h511, {7'h12, 7'h79, 7'h79});
      run8("sub10_200", 8'd10, 8'd200, 1'b1, 1'b0, 9'd190, 1'b1, 12'h190, {7'h79, 7'h18, 7'h40});
      run8("sub200_10", 8'd200, 8'd10, 1'b1, 1'b0, 9'd190, 1'b0, 12'h190, {7'h79, 7'h18, 7'h40});
      run8("sub77_77", 8'd77, 8'd77, 1'b1, 1'b1, 9'd0, 1'b0, 12'h000, {7'h7F, 7'h7F, 7'h40});
      run8("add0_0", 8'd0, 8'd0, 1'b0, 1'b0, 9'd0, 1'b0, 12'h000, {7'h7F, 7'h7F, 7'h40});
      run8("add5_4", 8'd5, 8'd4, 1'b0, 1'b0, 9'd9, 1'b0, 12'h009, {7'h7F, 7'h7F, 7'h18});
      run8("add100_5", 8'd100, 8'd5, 1'b0, 1'b0, 9'd105, 1'b0, 12'h105, {7'h79, 7'h40, 7'h12});

      // start pulsed mid-conversion must not queue a second job
      @(negedge clk);
      i8.a = 8'd3; i8.b = 8'd4; i8.sub = 1'b0; i8.cin = 1'b0; i8.start = 1'b1;
      @(negedge clk);
      i8.start = 1'b0;
      repeat (3) @(negedge clk);
      i8.start = 1'b1;
      @(negedge clk);
      i8.start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         if (i8.done) ndone++;
         @(negedge clk);
      end
      check("busy_start_ndone", ndone, 1);
      check("busy_start_bcd", i8.bcd, 12'h007);
      check("busy_start_idle", i8.busy, 0);

      // start held high: back-to-back accepts every W+4 cycles
      @(negedge clk);
      i8.a = 8'd3; i8.b = 8'd3; i8.start = 1'b1;
      t1 = -1; t2 = -1;
      for (int i = 0; i < 60 && t2 < 0; i++) begin
         @(negedge clk);
         if (i8.done) begin
            if (t1 < 0) t1 = i;
            else begin t2 = i; i8.start = 1'b0; end
         end
      end
      check("b2b_spacing", t2 - t1, 12);
      check("b2b_bcd", i8.bcd, 12'h006);
      repeat (3) @(negedge clk);
      check("b2b_stop", i8.busy, 0);

      // reset in the fourth conversion cycle discards the job
      i8.a = 8'd1; i8.b = 8'd1; i8.start = 1'b1;
      @(negedge clk);
      i8.start = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_busy_pre", i8.busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", i8.busy, 0);
      check("mid_rst_seg", i8.seg, 21'h1FFFFF);
      check("mid_rst_res", i8.result, 0);
      check("mid_rst_bcd", i8.bcd, 0);
      ndone = 0;
      repeat (2) begin @(negedge clk); if (i8.done) ndone++; end
      rst_n = 1'b1;
      repeat (15) begin @(negedge clk); if (i8.done) ndone++; end
      check("mid_rst_nodone", ndone, 0);
      run8("post_rst", 8'd1, 8'd2, 1'b0, 1'b0, 9'd3, 1'b0, 12'h003, {7'h7F, 7'h7F, 7'h30});

      // W=6 sweep
      @(negedge clk);
      i6.a = 6'd63; i6.b = 6'd63; i6.cin = 1'b1; i6.start = 1'b1;
      @(negedge clk);
      i6.start = 1'b0;
      lat = 1;
      while (!i6.done && lat < 40) begin @(negedge clk); lat++; end
      check("w6_lat", lat, 9);
      check("w6_res", i6.result, 7'd127);
      check("w6_bcd", i6.bcd, 12'h127);

      // W=16 sweep
      @(negedge clk);
      i16.a = 16'hFFFF; i16.b = 16'hFFFF; i16.cin = 1'b1; i16.start = 1'b1;
      @(negedge clk);
      i16.start = 1'b0;
      lat = 1;
      while (!i16.done && lat < 60) begin @(negedge clk); lat++; end
      check("w16_lat", lat, 19);
      check("w16_res", i16.result, 17'h1FFFF);
      check("w16_bcd", i16.bcd, 24'h131071);
      check("w16_seg", i16.seg, {7'h79, 7'h30, 7'h79, 7'h40, 7'h78, 7'h79});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
